// File: rtl/gpio_ctrl_if.sv
// MMIO slot bus shared by the peripherals: request strobes from the master,
// completion flags, read data and error status from the slave.
interface gpio_ctrl_if;
    logic        chip_select;
    logic        read;
    logic        write;
    logic        transaction_completed;
    logic [7:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        wr_done;
    logic        rd_done;
    logic        idle;
    logic        slave_error;
    logic        decode_error;

    modport master (
        output chip_select, read, write, transaction_completed, addr, wr_data,
        input  rd_data, wr_done, rd_done, idle, slave_error, decode_error
    );

    modport slave (
        input  chip_select, read, write, transaction_completed, addr, wr_data,
        output rd_data, wr_done, rd_done, idle, slave_error, decode_error
    );
endinterface

// File: rtl/gpio_ctrl.sv
// GPIO controller on an MMIO slot: output register with set/clear/toggle, synchronised
// inputs with edge-latched interrupt status. Define GPIO_DEBOUNCE_EN to add input debounce.
module gpio_ctrl #(
    parameter int NUM_INPUT       = 9,
    parameter int NUM_OUTPUT      = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  arst_n,
    gpio_ctrl_if.slave            bus,
    input  logic [NUM_INPUT-1:0]  in_ports,
    output logic [NUM_OUTPUT-1:0] out_ports,
    output logic                  irq
);
    localparam logic [7:0] A_OUT  = 8'h00;
    localparam logic [7:0] A_IN   = 8'h04;
    localparam logic [7:0] A_EN   = 8'h08;
    localparam logic [7:0] A_ST   = 8'h0C;
    localparam logic [7:0] A_EDGE = 8'h10;
    localparam logic [7:0] A_SET  = 8'h14;
    localparam logic [7:0] A_CLR  = 8'h18;
    localparam logic [7:0] A_TGL  = 8'h1C;

    if (NUM_INPUT < 1 || NUM_INPUT > 32 || NUM_OUTPUT < 1 || NUM_OUTPUT > 32 ||
        DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("gpio_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;
    state_t r_state, w_next;

    logic [7:0]            r_addr;
    logic [31:0]           r_wdata;
    logic                  r_is_write;
    logic [NUM_OUTPUT-1:0] r_out;
    logic [NUM_INPUT-1:0]  r_sync1, r_sync2, w_filt, r_prev;
    logic [NUM_INPUT-1:0]  r_irq_en, r_irq_st, r_edge_sel;
    logic [NUM_INPUT-1:0]  w_wdata_i, w_event, w_clr;
    logic [NUM_OUTPUT-1:0] w_wdata_o;
    logic [31:0]           r_rd_data;
    logic                  r_wr_done, r_rd_done, r_slv_err, r_dec_err, r_irq;
    logic                  w_req;
    logic                  w_unused;

    assign w_req     = bus.chip_select && (bus.read || bus.write);
    assign w_wdata_i = r_wdata[NUM_INPUT-1:0];
    assign w_wdata_o = r_wdata[NUM_OUTPUT-1:0];
    assign w_unused  = ^r_wdata;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_req) w_next = S_ACTIVE;
            S_ACTIVE: w_next = S_DONE;
            S_DONE:   if (bus.transaction_completed) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Request is captured in IDLE so the master may drop it once accepted.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
            r_out      <= '0;
            r_irq_en   <= '0;
            r_edge_sel <= '0;
            r_rd_data  <= '0;
            r_wr_done  <= 1'b0;
            r_rd_done  <= 1'b0;
            r_slv_err  <= 1'b0;
            r_dec_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_req) begin
                    r_addr     <= bus.addr;
                    r_wdata    <= bus.wr_data;
                    r_is_write <= bus.write;
                end
                S_ACTIVE: begin
                    r_wr_done <= r_is_write;
                    r_rd_done <= !r_is_write;
                    if (r_is_write) begin
                        case (r_addr)
                            A_OUT:   r_out      <= w_wdata_o;
                            A_IN:    r_slv_err  <= 1'b1;
                            A_EN:    r_irq_en   <= w_wdata_i;
                            A_ST:    begin end
                            A_EDGE:  r_edge_sel <= w_wdata_i;
                            A_SET:   r_out      <= r_out | w_wdata_o;
                            A_CLR:   r_out      <= r_out & ~w_wdata_o;
                            A_TGL:   r_out      <= r_out ^ w_wdata_o;
                            default: r_dec_err  <= 1'b1;
                        endcase
                    end else begin
                        case (r_addr)
                            A_OUT:               r_rd_data <= 32'(r_out);
                            A_IN:                r_rd_data <= 32'(w_filt);
                            A_EN:                r_rd_data <= 32'(r_irq_en);
                            A_ST:                r_rd_data <= 32'(r_irq_st);
                            A_EDGE:              r_rd_data <= 32'(r_edge_sel);
                            A_SET, A_CLR, A_TGL: r_slv_err <= 1'b1;
                            default:             r_dec_err <= 1'b1;
                        endcase
                    end
                end
                S_DONE: if (bus.transaction_completed) begin
                    r_rd_data <= '0;
                    r_wr_done <= 1'b0;
                    r_rd_done <= 1'b0;
                    r_slv_err <= 1'b0;
                    r_dec_err <= 1'b0;
                end
                default: begin end
            endcase
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0]     r_cnt [NUM_INPUT];
    logic [NUM_INPUT-1:0] r_filt;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_filt <= '0;
            for (int i = 0; i < NUM_INPUT; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_INPUT; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_filt[i] <= r_sync2[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_filt = r_filt;
`else
    assign w_filt = r_sync2;
`endif

    // Events compare the filtered value against its previous-cycle copy.
    assign w_event = (w_filt & ~r_prev & r_edge_sel) | (~w_filt & r_prev & ~r_edge_sel);
    assign w_clr   = (r_state == S_ACTIVE && r_is_write && r_addr == A_ST) ? w_wdata_i : '0;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_prev   <= '0;
            r_irq_st <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_sync1  <= in_ports;
            r_sync2  <= r_sync1;
            r_prev   <= w_filt;
            r_irq_st <= (r_irq_st & ~w_clr) | w_event;
            r_irq    <= |(r_irq_st & r_irq_en);
        end
    end

    assign bus.rd_data      = r_rd_data;
    assign bus.wr_done      = r_wr_done;
    assign bus.rd_done      = r_rd_done;
    assign bus.slave_error  = r_slv_err;
    assign bus.decode_error = r_dec_err;
    assign bus.idle         = (r_state == S_IDLE);
    assign out_ports        = r_out;
    assign irq              = r_irq;
endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl: register-access vector table plus hand-timed
// sequences for flag hold, async reset, interrupt latency/W1C race and input filtering.
module tb_gpio_ctrl;
`ifdef GPIO_DEBOUNCE_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic [8:0] in_ports = '0;
    logic [3:0] out_ports;
    logic       irq;
    int         n_vec = 0;
    int         n_err = 0;

    gpio_ctrl_if bus();

    gpio_ctrl #(.NUM_INPUT(9), .NUM_OUTPUT(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .arst_n(arst_n), .bus(bus),
        .in_ports(in_ports), .out_ports(out_ports), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          op;      // 0 read, 1 write, 2 read+write strobes together
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_wd;
        logic        exp_rdn;
        logic        exp_se;
        logic        exp_de;
        logic [3:0]  exp_out;
    } vec_t;

    vec_t vecs[23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic access(input int op, input logic [7:0] a, input logic [31:0] d,
                          output logic [31:0] rdat, output logic wd, output logic rdn,
                          output logic se, output logic de);
        int k;
        @(posedge clk); #1;
        bus.chip_select = 1'b1;
        bus.write       = (op != 0);
        bus.read        = (op != 1);
        bus.addr        = a;
        bus.wr_data     = d;
        @(posedge clk); #1;
        bus.chip_select = 1'b0;
        bus.write       = 1'b0;
        bus.read        = 1'b0;
        k = 0;
        while (!(bus.wr_done || bus.rd_done) && k < 8) begin
            @(posedge clk); #1;
            k++;
        end
        if (k == 8) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout addr %h: done flags never rose", a);
        end
        rdat = bus.rd_data;
        wd   = bus.wr_done;
        rdn  = bus.rd_done;
        se   = bus.slave_error;
        de   = bus.decode_error;
        bus.transaction_completed = 1'b1;
        @(posedge clk); #1;
        bus.transaction_completed = 1'b0;
    endtask

    task automatic rd_reg(input logic [7:0] a, output logic [31:0] v);
        logic wd, rdn, se, de;
        access(0, a, 32'h0, v, wd, rdn, se, de);
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] v;
        logic wd, rdn, se, de;
        access(1, a, d, v, wd, rdn, se, de);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic wd, rdn, se, de;

        bus.chip_select = 1'b0;
        bus.read = 1'b0;
        bus.write = 1'b0;
        bus.transaction_completed = 1'b0;
        bus.addr = '0;
        bus.wr_data = '0;

        vecs[0]  = '{1, 8'h00, 32'h0000000A, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 4'hA};
        vecs[1]  = '{1, 8'h00, 32'h00000005, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 4'h5};
        vecs[2]  = '{1, 8'h1C, 32'h00000003, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 4'h6};
        vecs[3]  = '{1, 8'h18, 32'h00000001, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 4'h6};
        vecs[4]  = '{1, 8'h14, 32'h00000008, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 4'hE};
        vecs[5]  = '{0, 8'h00, 32'h0,        32'hE,   1'b0, 1'b1, 1'b0, 1'b0, 4'hE};
        vecs[6]  = '{0, 8'h04, 32'h0,        32'h1A5, 1'b0, 1'b1, 1'b0, 1'b0, 4'hE};
        vecs[7]  = '{1, 8'h04, 32'hFFFFFFFF, 32'h0,   1'b1, 1'b0, 1'b1, 1'b0, 4'hE};
        vecs[8]  = '{0, 8'h04, 32'h0,        32'h1A5, 1'b0, 1'b1, 1'b0, 1'b0, 4'hE};
        vecs[9]  = '{0, 8'h14, 32'h0,        32'h0,   1'b0, 1'b1, 1'b1, 1'b0, 4'hE};
        vecs[10] = '{0, 8'h18, 32'h0,        32'h0,   1'b0, 1'b1, 1'b1, 1'b0, 4'hE};
        vecs[11] = '{0, 8'h1C, 32'h0,        32'h0,   1'b0, 1'b1, 1'b1, 1'b0, 4'hE};
        vecs[12] = '{0, 8'h20, 32'h0,        32'h0,   1'b0, 1'b1, 1'b0, 1'b1, 4'hE};
        vecs[13] = '{1, 8'h20, 32'h00000001, 32'h0,   1'b1, 1'b0, 1'b0, 1'b1, 4'hE};
        vecs[14] = '{0, 8'h03, 32'h0,        32'h0,   1'b0, 1'b1, 1'b0, 1'b1, 4'hE};
        vecs[15] = '{1, 8'h00, 32'hFFFFFFF3, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 4'h3};
        vecs[16] = '{0, 8'h00, 32'h0,        32'h3,   1'b0, 1'b1, 1'b0, 1'b0, 4'h3};
        vecs[17] = '{2, 8'h08, 32'hFFFFFFFF, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 4'h3};
        vecs[18] = '{0, 8'h08, 32'h0,        32'h1FF, 1'b0, 1'b1, 1'b0, 1'b0, 4'h3};
        vecs[19] = '{1, 8'h10, 32'h00000000, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 4'h3};
        vecs[20] = '{0, 8'h0C, 32'h0,        32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 4'h3};
        vecs[21] = '{0, 8'h10, 32'h0,        32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 4'h3};
        vecs[22] = '{1, 8'h08, 32'h00000000, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 4'h3};

        // Reset state
        #22 arst_n = 1'b1;
        #1;
        chk("rst out_ports", out_ports, 0);
        chk("rst rd_data", bus.rd_data, 0);
        chk("rst wr_done", bus.wr_done, 0);
        chk("rst rd_done", bus.rd_done, 0);
        chk("rst slave_error", bus.slave_error, 0);
        chk("rst decode_error", bus.decode_error, 0);
        chk("rst irq", irq, 0);
        chk("rst idle", bus.idle, 1);

        // Exact handshake timing, flags held while transaction_completed is low
        @(posedge clk); #1;
        bus.chip_select = 1'b1; bus.write = 1'b1; bus.addr = 8'h00; bus.wr_data = 32'hA;
        @(posedge clk); #1;
        bus.chip_select = 1'b0; bus.write = 1'b0;
        chk("active idle", bus.idle, 0);
        chk("active wr_done", bus.wr_done, 0);
        @(posedge clk); #1;
        chk("done wr_done", bus.wr_done, 1);
        chk("done out_ports", out_ports, 4'hA);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold wr_done", bus.wr_done, 1);
            chk("hold idle", bus.idle, 0);
        end
        bus.transaction_completed = 1'b1;
        @(posedge clk); #1;
        bus.transaction_completed = 1'b0;
        chk("release idle", bus.idle, 1);
        chk("release wr_done", bus.wr_done, 0);

        // Reset asserted while the FSM is in ACTIVE
        @(posedge clk); #1;
        bus.chip_select = 1'b1; bus.write = 1'b1; bus.addr = 8'h00; bus.wr_data = 32'h5;
        @(posedge clk); #1;
        bus.chip_select = 1'b0; bus.write = 1'b0;
        chk("pre-reset idle", bus.idle, 0);
        #2 arst_n = 1'b0;
        #1;
        chk("mid-reset idle", bus.idle, 1);
        chk("mid-reset out_ports", out_ports, 0);
        @(posedge clk); #1;
        arst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-reset out_ports", out_ports, 0);
        chk("post-reset wr_done", bus.wr_done, 0);
        chk("post-reset idle", bus.idle, 1);

        // Register access table with inputs held at 0x1A5
        in_ports = 9'h1A5;
        repeat (12) @(posedge clk);
        for (int i = 0; i < 23; i++) begin
            access(vecs[i].op, vecs[i].addr, vecs[i].wdata, v, wd, rdn, se, de);
            chk($sformatf("v%0d rd_data", i), v, vecs[i].exp_rd);
            chk($sformatf("v%0d wr_done", i), wd, vecs[i].exp_wd);
            chk($sformatf("v%0d rd_done", i), rdn, vecs[i].exp_rdn);
            chk($sformatf("v%0d slave_error", i), se, vecs[i].exp_se);
            chk($sformatf("v%0d decode_error", i), de, vecs[i].exp_de);
            chk($sformatf("v%0d out_ports", i), out_ports, vecs[i].exp_out);
            chk($sformatf("v%0d irq", i), irq, 0);
        end

        // Interrupt: rising on bit 0, latency, W1C, and W1C racing a new event
        wr_reg(8'h10, 32'h1);
        wr_reg(8'h08, 32'h1);
        in_ports = 9'h000;
        repeat (12) @(posedge clk);
        wr_reg(8'h0C, 32'h1FF);
        rd_reg(8'h0C, v);
        chk("status cleared", v, 0);
        chk("irq cleared", irq, 0);
        @(posedge clk); #1;
        in_ports = 9'h001;
        repeat (3 + LAT) @(posedge clk);
        #1;
        chk("irq before latency", irq, 0);
        @(posedge clk); #1;
        chk("irq after latency", irq, 1);
        rd_reg(8'h0C, v);
        chk("status rise", v, 32'h1);
        wr_reg(8'h0C, 32'h1);
        chk("irq after w1c", irq, 0);
        rd_reg(8'h0C, v);
        chk("status after w1c", v, 0);
        in_ports = 9'h000;
        repeat (12) @(posedge clk);
        rd_reg(8'h0C, v);
        chk("status falling ignored", v, 0);
        @(posedge clk); #1;
        in_ports = 9'h001;
        repeat (LAT) @(posedge clk);
        wr_reg(8'h0C, 32'h1);
        rd_reg(8'h0C, v);
        chk("status set wins", v, 32'h1);
        chk("irq set wins", irq, 1);

`ifdef GPIO_DEBOUNCE_EN
        // Short pulse rejected; held level accepted after the stable window
        @(posedge clk); #1;
        in_ports = 9'h003;
        repeat (3) @(posedge clk);
        #1;
        in_ports = 9'h001;
        repeat (12) @(posedge clk);
        rd_reg(8'h04, v);
        chk("debounce pulse", v, 32'h001);
        @(posedge clk); #1;
        in_ports = 9'h003;
        repeat (3) @(posedge clk);
        rd_reg(8'h04, v);
        chk("debounce early", v, 32'h001);
        rd_reg(8'h04, v);
        chk("debounce settled", v, 32'h003);
`else
        // Unfiltered path: value is visible two edges after the pin change
        @(posedge clk); #1;
        in_ports = 9'h003;
        rd_reg(8'h04, v);
        chk("sync latency", v, 32'h003);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
